// File: rtl/mon_mod_inverse_wsr_if.sv
// Handshake and operand bus of the Montgomery-constant engine.
// master drives the request side, slave is the engine.
interface mon_mod_inverse_wsr_if #(
  parameter int W  = 1024,
  parameter int LW = 11
);
  logic          iStart;
  logic [W-1:0]  iX;
  logic [LW-1:0] iLength;
  logic          iNegate;
  logic          oBusy;
  logic          oDataValid;
  logic          oError;
  logic [W-1:0]  oZ;

  modport master (
    output iStart, iX, iLength, iNegate,
    input  oBusy, oDataValid, oError, oZ
  );

  modport slave (
    input  iStart, iX, iLength, iNegate,
    output oBusy, oDataValid, oError, oZ
  );
endinterface

// File: rtl/mon_mod_inverse_wsr.sv
// Z = X^-1 (or -X^-1) mod 2^L by bit-serial Hensel lifting.
// Optional MODINV_WORD_SKIP_EN skips the all-zero low words of Xr<<i.
module mon_mod_inverse_wsr #(
  parameter int W  = 1024,
  parameter int DW = 32,
  parameter int LW = 11
) (
  input logic iClk,
  input logic iRst,
  mon_mod_inverse_wsr_if.slave bus
);
  localparam int NW = W / DW;
  localparam int JW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ADD,
    DONE
  } state_t;

  state_t                state;
  logic [W-1:0]          xr;
  logic [W-1:0]          y;
  logic [NW-1:0][DW-1:0] t;
  logic [NW-1:0][DW-1:0] x_sh;
  logic [LW-1:0]         i;
  logic [LW-1:0]         len;
  logic [JW-1:0]         j;
  logic [JW-1:0]         j_start;
  logic                  c;
  logic                  neg;
  logic [W-1:0]          t_sh;
  logic [W-1:0]          mask;
  logic [W-1:0]          z_next;
  logic [DW:0]           sum;
  logic                  bad;

  // Shifted operand, current T bit, word adder and final result.
  always_comb begin
    x_sh   = xr << i;
    t_sh   = t >> i;
    mask   = (W'(1) << len) - W'(1);
    sum    = {1'b0, t[j]} + {1'b0, x_sh[j]}
           + {{DW{1'b0}}, c};
    z_next = neg ? ((~y + W'(1)) & mask)
                 : (y & mask);
    bad    = ~bus.iX[0]
           | (bus.iLength == '0)
           | (bus.iLength > LW'(W));
`ifdef MODINV_WORD_SKIP_EN
    j_start = JW'(i / LW'(DW));
`else
    j_start = '0;
`endif
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state          <= IDLE;
      xr             <= '0;
      y              <= '0;
      t              <= '0;
      i              <= '0;
      len            <= '0;
      j              <= '0;
      c              <= 1'b0;
      neg            <= 1'b0;
      bus.oBusy      <= 1'b0;
      bus.oDataValid <= 1'b0;
      bus.oError     <= 1'b0;
      bus.oZ         <= '0;
    end else begin
      bus.oDataValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.iStart) begin
            bus.oBusy  <= 1'b1;
            bus.oError <= 1'b0;
            bus.oZ     <= '0;
            len        <= bus.iLength;
            neg        <= bus.iNegate;
            if (bad) begin
              state <= DONE;
            end else begin
              xr    <= bus.iX;
              y     <= W'(1);
              t     <= bus.iX;
              i     <= LW'(1);
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (i == len) begin
            bus.oZ         <= z_next;
            bus.oDataValid <= 1'b1;
            bus.oBusy      <= 1'b0;
            state          <= IDLE;
          end else if (t_sh[0]) begin
            y     <= y | (W'(1) << i);
            j     <= j_start;
            c     <= 1'b0;
            state <= ADD;
          end else begin
            i <= i + LW'(1);
          end
        end
        ADD: begin
          t[j] <= sum[DW-1:0];
          c    <= sum[DW];
          if (j == JW'(NW - 1)) begin
            i     <= i + LW'(1);
            state <= CHECK;
          end else begin
            j <= j + JW'(1);
          end
        end
        DONE: begin
          bus.oError     <= 1'b1;
          bus.oZ         <= '0;
          bus.oDataValid <= 1'b1;
          bus.oBusy      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mon_mod_inverse_wsr.sv
// Scoreboard bench for mon_mod_inverse_wsr (W=64, DW=32).
// Honours MODINV_WORD_SKIP_EN in its latency model.
module tb_mon_mod_inverse_wsr;
  localparam int W  = 64;
  localparam int DW = 32;
  localparam int LW = 7;
  localparam int NW = W / DW;

  typedef struct {
    logic [63:0] x;
    int          l;
    logic        n;
    logic [63:0] z;
    logic        e;
    int          lat;
    int          acc;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  job_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mon_mod_inverse_wsr_if #(.W(W), .LW(LW)) bus();

  mon_mod_inverse_wsr #(.W(W), .DW(DW), .LW(LW)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mask_of(input int l);
    if (l >= 64) return '1;
    return (64'd1 << l) - 64'd1;
  endfunction

  // Newton iteration: each step doubles the number of correct low bits.
  function automatic logic [63:0] inv64(input logic [63:0] x);
    logic [63:0] y = x;
    repeat (6) y = y * (64'd2 - x * y);
    return y;
  endfunction

  function automatic int lat_of(input logic [63:0] y, input int l);
    int a = l;
    for (int b = 1; b < l; b++) begin
      logic [63:0] s = y >> b;
      if (s[0]) begin
`ifdef MODINV_WORD_SKIP_EN
        a += NW - b / DW;
`else
        a += NW;
`endif
      end
    end
    return a;
  endfunction

  task automatic model(input logic [63:0] x, input int l, input logic n,
                       output logic [63:0] z, output logic e,
                       output int lat);
    logic [63:0] y;
    if (!x[0] || l == 0 || l > 64) begin
      z = '0; e = 1'b1; lat = 1;
    end else begin
      y   = inv64(x) & mask_of(l);
      z   = n ? ((-y) & mask_of(l)) : y;
      e   = 1'b0;
      lat = lat_of(y, l);
    end
  endtask

  task automatic issue(input logic [63:0] x, input int l, input logic n,
                       input logic [63:0] ez, input logic ee,
                       input int el, input bit push);
    int guard = 0;
    job_t jb;
    while (bus.oBusy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("busy_timeout", 64'd1, 64'd0);
    bus.iStart  = 1'b1;
    bus.iX      = x;
    bus.iLength = LW'(l);
    bus.iNegate = n;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    if (push) begin
      jb = '{x: x, l: l, n: n, z: ez, e: ee, lat: el, acc: cyc};
      q.push_back(jb);
    end
  endtask

  task automatic job(input logic [63:0] x, input int l, input logic n);
    logic [63:0] z;
    logic e;
    int lat;
    model(x, l, n, z, e, lat);
    issue(x, l, n, z, e, lat, 1'b1);
    if (lat > 4) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        bus.iStart  = 1'b1;
        bus.iX      = {$urandom, $urandom};
        bus.iLength = LW'($urandom_range(0, 70));
        bus.iNegate = 1'($urandom);
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
      end
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding job.
  initial begin
    job_t jb;
    logic [63:0] prod;
    forever begin
      @(negedge clk);
      if (bus.oDataValid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          jb = q.pop_front();
          chk("z", bus.oZ, jb.z);
          chk("error", 64'(bus.oError), 64'(jb.e));
          chk("latency", 64'(cyc - jb.acc), 64'(jb.lat));
          chk("busy_at_valid", 64'(bus.oBusy), 64'd0);
          if (!jb.e) begin
            prod = (jb.x * bus.oZ) & mask_of(jb.l);
            chk("x_times_z", prod,
                jb.n ? mask_of(jb.l) : 64'd1);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    bus.iStart  = 1'b0;
    bus.iX      = '0;
    bus.iLength = '0;
    bus.iNegate = 1'b0;
    #3;
    chk("reset_busy", 64'(bus.oBusy), 64'd0);
    chk("reset_valid", 64'(bus.oDataValid), 64'd0);
    chk("reset_error", 64'(bus.oError), 64'd0);
    chk("reset_z", bus.oZ, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(64'd3, 8, 1'b0, 64'hAB, 1'b0, 16, 1'b1);
    issue(64'd3, 8, 1'b1, 64'h55, 1'b0, 16, 1'b1);
`ifdef MODINV_WORD_SKIP_EN
    issue('1, 64, 1'b0, '1, 1'b0, 158, 1'b1);
    issue('1, 64, 1'b1, 64'd1, 1'b0, 158, 1'b1);
`else
    issue('1, 64, 1'b0, '1, 1'b0, 190, 1'b1);
    issue('1, 64, 1'b1, 64'd1, 1'b0, 190, 1'b1);
`endif
    issue(64'd4, 8, 1'b0, 64'd0, 1'b1, 1, 1'b1);
    issue(64'd3, 0, 1'b0, 64'd0, 1'b1, 1, 1'b1);
    issue(64'd3, 65, 1'b0, 64'd0, 1'b1, 1, 1'b1);
    issue(64'd5, 1, 1'b1, 64'd1, 1'b0, 1, 1'b1);

    issue(64'd3, 8, 1'b0, 64'd0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.oBusy), 64'd0);
    chk("abort_valid", 64'(bus.oDataValid), 64'd0);
    chk("abort_error", 64'(bus.oError), 64'd0);
    chk("abort_z", bus.oZ, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(64'd1, 8, 1'b0, 64'd1, 1'b0, 8, 1'b1);

    job(64'd3, 8, 1'b0);
    job(64'hFFFF_FFFF_0000_0001, 64, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0)
        job({$urandom, $urandom}, $urandom_range(0, 70), 1'($urandom));
      else
        job({$urandom, $urandom} | 64'd1, $urandom_range(1, 64),
            1'($urandom));
    end

    guard = 0;
    while ((q.size() != 0 || bus.oBusy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
